// File: rtl/mem_access_unit_if.sv
// Data-memory port bundle for mem_access_unit: req/gnt request channel plus rvalid/rdata response.
// The master modport is the access unit, the slave modport is the data memory.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [3:0]            dmem_be;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic                  dmem_gnt;
  logic                  dmem_rvalid;
  logic [DATA_WIDTH-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Execution-stage load/store unit: EA, alignment, byte lanes, req/gnt/rvalid handshake, load extension.
// Optional watchdog on stalled memory handshakes is enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RD_WIDTH       = 5,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CTRL_MEM_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      uop_valid,
  input  logic                      uop_is_mem_load,
  input  logic                      uop_is_mem_store,
  input  logic [CTRL_MEM_WIDTH-1:0] ctrl_mem,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [ADDR_WIDTH-1:0]     imm,
  input  logic [DATA_WIDTH-1:0]     store_data,
  input  logic [RD_WIDTH-1:0]       rd_in,
  output logic                      uop_ready,
  mem_access_unit_if.master         dmem,
  output logic                      wb_valid,
  output logic [RD_WIDTH-1:0]       wb_rd,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      store_done,
  output logic                      misalign_exc,
  output logic [ADDR_WIDTH-1:0]     exc_addr,
  output logic                      bus_err
);

  localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_LB  = CTRL_MEM_WIDTH'(1);
  localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_LH  = CTRL_MEM_WIDTH'(2);
  localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_LW  = CTRL_MEM_WIDTH'(3);
  localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_LBU = CTRL_MEM_WIDTH'(4);
  localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_LHU = CTRL_MEM_WIDTH'(5);
  localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_SB  = CTRL_MEM_WIDTH'(6);
  localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_SH  = CTRL_MEM_WIDTH'(7);
  localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_SW  = CTRL_MEM_WIDTH'(8);

  if (DATA_WIDTH != 32) begin : g_chk_data_width
    $error("mem_access_unit supports DATA_WIDTH == 32 only");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
    $error("mem_access_unit needs TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RSP} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  state_e                r_state, w_state_nxt;
  size_e                 w_size, r_size;
  logic                  w_signed, r_signed;
  logic [ADDR_WIDTH-1:0] w_ea, r_addr, r_exc_addr;
  logic                  w_accept, w_misalign;
  logic [3:0]            w_be, r_be;
  logic [DATA_WIDTH-1:0] w_wdata, r_wdata;
  logic                  r_we;
  logic [RD_WIDTH-1:0]   r_rd, r_wb_rd;
  logic [DATA_WIDTH-1:0] w_lane, w_load_ext, r_wb_data;
  logic                  r_wb_valid, r_store_done, r_misalign;
  logic                  w_tmo_hit, w_tmo_fire;

  // Access size and signedness come from ctrl_mem; direction comes from the load/store flags.
  always_comb begin
    w_size   = SZ_W;
    w_signed = 1'b0;
    case (ctrl_mem)
      CTRL_LB:           begin w_size = SZ_B; w_signed = 1'b1; end
      CTRL_LH:           begin w_size = SZ_H; w_signed = 1'b1; end
      CTRL_LBU, CTRL_SB: w_size = SZ_B;
      CTRL_LHU, CTRL_SH: w_size = SZ_H;
      CTRL_LW, CTRL_SW:  w_size = SZ_W;
      default:           ;
    endcase
  end

  assign w_ea       = base_addr + imm;
  assign w_accept   = uop_valid & uop_ready & (uop_is_mem_load ^ uop_is_mem_store) & (|ctrl_mem);
  assign w_misalign = ((w_size == SZ_H) & w_ea[0]) | ((w_size == SZ_W) & (|w_ea[1:0]));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = '0;
    case (w_size)
      SZ_B:    w_be = 4'b0001 << w_ea[1:0];
      SZ_H:    w_be = 4'b0011 << w_ea[1:0];
      default: ;
    endcase
    if (uop_is_mem_store) begin
      case (w_size)
        SZ_B:    w_wdata = {4{store_data[7:0]}};
        SZ_H:    w_wdata = {2{store_data[15:0]}};
        default: w_wdata = store_data;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_tmo_fire  = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept && !w_misalign) w_state_nxt = S_REQ;
      S_REQ: begin
        if (dmem.dmem_gnt)  w_state_nxt = r_we ? S_IDLE : S_WAIT_RSP;
        else if (w_tmo_hit) begin w_state_nxt = S_IDLE; w_tmo_fire = 1'b1; end
      end
      S_WAIT_RSP: begin
        if (dmem.dmem_rvalid) w_state_nxt = S_IDLE;
        else if (w_tmo_hit)   begin w_state_nxt = S_IDLE; w_tmo_fire = 1'b1; end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_lane = dmem.dmem_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load_ext = w_lane;
    case (r_size)
      SZ_B:    w_load_ext = {{24{r_signed & w_lane[7]}}, w_lane[7:0]};
      SZ_H:    w_load_ext = {{16{r_signed & w_lane[15]}}, w_lane[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_be         <= '0;
      r_wdata      <= '0;
      r_size       <= SZ_W;
      r_signed     <= 1'b0;
      r_rd         <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
      r_store_done <= 1'b0;
      r_misalign   <= 1'b0;
      r_exc_addr   <= '0;
    end else begin
      r_wb_valid   <= 1'b0;
      r_store_done <= 1'b0;
      r_misalign   <= 1'b0;
      if (w_accept) begin
        r_addr   <= w_ea;
        r_we     <= uop_is_mem_store;
        r_be     <= w_be;
        r_wdata  <= w_wdata;
        r_size   <= w_size;
        r_signed <= w_signed;
        r_rd     <= rd_in;
        if (w_misalign) begin
          r_misalign <= 1'b1;
          r_exc_addr <= w_ea;
        end
      end
      if (r_state == S_REQ && dmem.dmem_gnt && r_we) r_store_done <= 1'b1;
      if (r_state == S_WAIT_RSP && dmem.dmem_rvalid) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= r_rd;
        r_wb_data  <= w_load_ext;
      end
      if (w_tmo_fire) r_exc_addr <= r_addr;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_bus_err;

  // Counter restarts on every state change, so REQ and WAIT_RSP each get the full budget.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo_cnt <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_tmo_fire;
      if (w_state_nxt != r_state)  r_tmo_cnt <= '0;
      else if (r_state != S_IDLE)  r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_tmo_hit = (r_state != S_IDLE) && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_err   = r_bus_err;
`else
  assign w_tmo_hit = 1'b0;
  assign bus_err   = 1'b0;
`endif

  assign uop_ready       = (r_state == S_IDLE);
  assign dmem.dmem_req   = (r_state == S_REQ);
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign dmem.dmem_be    = r_be;
  assign dmem.dmem_wdata = r_wdata;
  assign wb_valid        = r_wb_valid;
  assign wb_rd           = r_wb_rd;
  assign wb_data         = r_wb_data;
  assign store_done      = r_store_done;
  assign misalign_exc    = r_misalign;
  assign exc_addr        = r_exc_addr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver queues expected requests and result pulses,
// a negedge monitor pops and compares them whenever the DUT presents a request or a pulse.
`timescale 1ns/1ps
module tb_mem_access_unit;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam logic [CW-1:0] LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4, LHU = 4'd5,
                            SB = 4'd6, SH = 4'd7, SW = 4'd8;

  typedef enum logic [1:0] {EV_LOAD, EV_STORE, EV_MIS, EV_BUS} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    int unsigned cyc;
    logic [4:0]  rd;
    logic [31:0] val;
  } ev_t;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          uop_valid = 1'b0, uop_is_mem_load = 1'b0, uop_is_mem_store = 1'b0;
  logic [CW-1:0] ctrl_mem = '0;
  logic [AW-1:0] base_addr = '0, imm = '0;
  logic [DW-1:0] store_data = '0;
  logic [RW-1:0] rd_in = '0;
  logic          uop_ready, wb_valid, store_done, misalign_exc, bus_err;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] exc_addr;

  mem_access_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dmem_bus ();

  mem_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_WIDTH(RW),
                    .TIMEOUT_CYCLES(16), .CTRL_MEM_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .uop_valid(uop_valid), .uop_is_mem_load(uop_is_mem_load),
    .uop_is_mem_store(uop_is_mem_store), .ctrl_mem(ctrl_mem), .base_addr(base_addr),
    .imm(imm), .store_data(store_data), .rd_in(rd_in), .uop_ready(uop_ready),
    .dmem(dmem_bus), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .store_done(store_done), .misalign_exc(misalign_exc), .exc_addr(exc_addr), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   failures = 0;
  ev_t  ev_q[$];
  req_t req_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the request bus every cycle it is active and every result pulse.
  always @(negedge clk) begin : monitor
    int       n;
    ev_t      e;
    ev_kind_e seen;
    if (dmem_bus.dmem_req) begin
      if (req_q.size() == 0) check("unexpected_req", 64'(dmem_bus.dmem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        check("req_we",    64'(dmem_bus.dmem_we),    64'(req_q[0].we));
        check("req_addr",  64'(dmem_bus.dmem_addr),  64'(req_q[0].addr));
        check("req_be",    64'(dmem_bus.dmem_be),    64'(req_q[0].be));
        check("req_wdata", 64'(dmem_bus.dmem_wdata), 64'(req_q[0].wdata));
        if (dmem_bus.dmem_gnt) void'(req_q.pop_front());
      end
    end
    n = int'(wb_valid) + int'(store_done) + int'(misalign_exc) + int'(bus_err);
    if (n > 1) check("multi_pulse", 64'(n), 64'd1);
    else if (n == 1) begin
      seen = wb_valid ? EV_LOAD : store_done ? EV_STORE : misalign_exc ? EV_MIS : EV_BUS;
      if (ev_q.size() == 0) check("unexpected_pulse", 64'(seen), 64'hFF);
      else begin
        e = ev_q.pop_front();
        check("pulse_kind",  64'(seen), 64'(e.kind));
        check("pulse_cycle", 64'(cyc),  64'(e.cyc));
        if (e.kind == EV_LOAD) begin
          check("wb_rd",   64'(wb_rd),   64'(e.rd));
          check("wb_data", 64'(wb_data), 64'(e.val));
        end else if (e.kind != EV_STORE) begin
          check("exc_addr", 64'(exc_addr), 64'(e.val));
        end
      end
    end
  end

  function automatic req_t mk_req(input logic we, input logic [31:0] addr,
                                  input logic [3:0] be, input logic [31:0] wdata);
    mk_req.we = we; mk_req.addr = addr; mk_req.be = be; mk_req.wdata = wdata;
  endfunction

  function automatic ev_t mk_ev(input ev_kind_e kind, input int unsigned c,
                                input logic [4:0] rd, input logic [31:0] val);
    mk_ev.kind = kind; mk_ev.cyc = c; mk_ev.rd = rd; mk_ev.val = val;
  endfunction

  // Presents one uop for exactly one edge; returns #1 after that edge.
  task automatic issue(input logic ld, input logic st, input logic [CW-1:0] ctrl,
                       input logic [31:0] base, input logic [31:0] off,
                       input logic [31:0] sd, input logic [4:0] rd);
    uop_valid = 1'b1; uop_is_mem_load = ld; uop_is_mem_store = st; ctrl_mem = ctrl;
    base_addr = base; imm = off; store_data = sd; rd_in = rd;
    @(posedge clk); #1;
    uop_valid = 1'b0; uop_is_mem_load = 1'b0; uop_is_mem_store = 1'b0; ctrl_mem = '0;
  endtask

  // Plays the memory side of one accepted access and queues the expected completion pulse.
  task automatic mem_txn(input req_t r, input int gnt_dly, input int rsp_dly,
                         input logic [31:0] rdata, input logic [4:0] rd,
                         input logic [31:0] exp_data, input logic junk_rvalid);
    req_q.push_back(r);
    repeat (gnt_dly) begin @(posedge clk); #1; end
    dmem_bus.dmem_gnt = 1'b1;
    if (junk_rvalid) begin dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'hDEAD_BEEF; end
    @(posedge clk); #1;
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0;
    if (r.we) ev_q.push_back(mk_ev(EV_STORE, cyc, 5'd0, 32'd0));
    else begin
      repeat (rsp_dly) begin @(posedge clk); #1; end
      dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = rdata;
      @(posedge clk); #1;
      dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = '0;
      ev_q.push_back(mk_ev(EV_LOAD, cyc, rd, exp_data));
    end
  endtask

  initial begin
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_uop_ready", 64'(uop_ready), 64'd1);
    check("rst_dmem_req",  64'(dmem_bus.dmem_req), 64'd0);
    check("rst_dmem_be",   64'(dmem_bus.dmem_be), 64'd0);
    check("rst_wb_valid",  64'(wb_valid), 64'd0);
    check("rst_wb_data",   64'(wb_data), 64'd0);
    check("rst_exc_addr",  64'(exc_addr), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // LB 0x1000+3: top lane 0x80 sign-extends; minimum latency
    issue(1, 0, LB, 32'h1000, 32'd3, 32'd0, 5'd5);
    check("busy_uop_ready", 64'(uop_ready), 64'd0);
    mem_txn(mk_req(0, 32'h1000, 4'b1000, 32'd0), 0, 0, 32'h80FF_FFFF, 5'd5, 32'hFFFF_FF80, 0);
    // back-to-back LHU then LH on the same data
    issue(1, 0, LHU, 32'h2000, 32'd2, 32'd0, 5'd6);
    mem_txn(mk_req(0, 32'h2000, 4'b1100, 32'd0), 0, 0, 32'h8001_1234, 5'd6, 32'h0000_8001, 0);
    issue(1, 0, LH, 32'h2000, 32'd2, 32'd0, 5'd7);
    mem_txn(mk_req(0, 32'h2000, 4'b1100, 32'd0), 1, 2, 32'h8001_1234, 5'd7, 32'hFFFF_8001, 1);
    // SB with gnt held low 3 cycles: request checked stable on 4 cycles
    issue(0, 1, SB, 32'h3000, 32'd1, 32'h1234_56AB, 5'd0);
    mem_txn(mk_req(1, 32'h3000, 4'b0010, 32'hABAB_ABAB), 3, 0, 32'd0, 5'd0, 32'd0, 0);
    check("hold_wb_data", 64'(wb_data), 64'hFFFF_8001);
    check("hold_wb_rd",   64'(wb_rd),   64'd7);
    // misaligned LW at 0x4002
    issue(1, 0, LW, 32'h4000, 32'd2, 32'd0, 5'd8);
    ev_q.push_back(mk_ev(EV_MIS, cyc, 5'd0, 32'h4002));
    check("mis_uop_ready", 64'(uop_ready), 64'd1);
    // SH with negative offset and SW whose EA wraps past 2^32
    issue(0, 1, SH, 32'h5010, 32'hFFFF_FFF2, 32'hCAFE_BEEF, 5'd0);
    mem_txn(mk_req(1, 32'h5000, 4'b1100, 32'hBEEF_BEEF), 0, 0, 32'd0, 5'd0, 32'd0, 0);
    issue(0, 1, SW, 32'hFFFF_FFFC, 32'd8, 32'hDEAD_1234, 5'd0);
    mem_txn(mk_req(1, 32'h0000_0004, 4'b1111, 32'hDEAD_1234), 1, 0, 32'd0, 5'd0, 32'd0, 0);
    // LBU lane 1, misaligned LH, then LW with slow response
    issue(1, 0, LBU, 32'h6000, 32'd1, 32'd0, 5'd9);
    mem_txn(mk_req(0, 32'h6000, 4'b0010, 32'd0), 0, 1, 32'h1122_83FF, 5'd9, 32'h0000_0083, 0);
    issue(1, 0, LH, 32'h7000, 32'd1, 32'd0, 5'd10);
    ev_q.push_back(mk_ev(EV_MIS, cyc, 5'd0, 32'h7001));
    issue(1, 0, LW, 32'h8000, 32'd4, 32'd0, 5'd31);
    mem_txn(mk_req(0, 32'h8004, 4'b1111, 32'd0), 2, 3, 32'h89AB_CDEF, 5'd31, 32'h89AB_CDEF, 0);

    // ignored uops: load and store both set, and ctrl_mem == 0
    issue(1, 1, LW, 32'h9000, 32'd1, 32'd0, 5'd1);
    issue(1, 0, 4'd0, 32'h9000, 32'd0, 32'd0, 5'd1);
    @(posedge clk); #1;
    check("ignored_uop_ready", 64'(uop_ready), 64'd1);

    // reset while waiting for the load response, then a stale rvalid
    issue(1, 0, LW, 32'h9000, 32'd0, 32'd0, 5'd3);
    req_q.push_back(mk_req(0, 32'h9000, 4'b1111, 32'd0));
    dmem_bus.dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_bus.dmem_gnt = 1'b0;
    check("wait_uop_ready", 64'(uop_ready), 64'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_uop_ready", 64'(uop_ready), 64'd1);
    check("mid_rst_dmem_req",  64'(dmem_bus.dmem_req), 64'd0);
    check("mid_rst_dmem_addr", 64'(dmem_bus.dmem_addr), 64'd0);
    check("mid_rst_wb_data",   64'(wb_data), 64'd0);
    check("mid_rst_wb_rd",     64'(wb_rd), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = '0;
    repeat (2) @(posedge clk); #1;
    check("post_rst_wb_data", 64'(wb_data), 64'd0);
    issue(1, 0, LB, 32'hA000, 32'd0, 32'd0, 5'd2);
    mem_txn(mk_req(0, 32'hA000, 4'b0001, 32'd0), 0, 0, 32'h0000_007F, 5'd2, 32'h0000_007F, 0);

`ifdef MEM_TIMEOUT_EN
    // gnt never arrives: bus_err after 16 REQ cycles
    issue(0, 1, SW, 32'hB000, 32'd0, 32'h0000_0001, 5'd0);
    req_q.push_back(mk_req(1, 32'hB000, 4'b1111, 32'h0000_0001));
    repeat (16) begin @(posedge clk); #1; end
    req_q.delete();
    ev_q.push_back(mk_ev(EV_BUS, cyc, 5'd0, 32'hB000));
    check("tmo_dmem_req",  64'(dmem_bus.dmem_req), 64'd0);
    check("tmo_uop_ready", 64'(uop_ready), 64'd1);
`else
    // without the watchdog a long gnt stall just keeps the request up
    issue(0, 1, SW, 32'hB000, 32'd0, 32'h0000_0001, 5'd0);
    mem_txn(mk_req(1, 32'hB000, 4'b1111, 32'h0000_0001), 20, 0, 32'd0, 5'd0, 32'd0, 0);
    check("no_tmo_bus_err", 64'(bus_err), 64'd0);
`endif

    repeat (3) @(posedge clk); #1;
    check("events_drained",   64'(ev_q.size()),  64'd0);
    check("requests_drained", 64'(req_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
